keypad_entry_guard: RTL and testbench
=====================================

KEYPAD_ENTRY_GUARD -- requirements
Module: keypad_entry_guard

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized high samples of submit needed to accept, or low samples needed to release.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles an accepted code is presented on keypad_out.
REQ-003 Parameter MAX_FAILS, default 3: consecutive rejected codes that trigger lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 1024: lockout duration in cycles.
REQ-005 Parameter MAIN_CODE, default 4'b1010: fixed master access code.
REQ-006 Parameter IDLE_CODE, default 4'b0000: value driven on keypad_out when no code is presented.
REQ-007 clk  input  1  single system clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 keypad_raw  input  4  raw code switches, asynchronous to clk.
REQ-010 submit  input  1  raw enter button, asynchronous, active-high.
REQ-011 temp_access_code  input  4  temporary code, synchronous to clk.
REQ-012 keypad_out  output  4  code presented to the downstream lock's keypad input.
REQ-013 code_valid  output  1  one-cycle pulse on the first cycle of each presentation.
REQ-014 code_accepted  output  1  one-cycle pulse, coincident with code_valid, when the code matches.
REQ-015 lockout  output  1  high while in LOCKOUT.
REQ-016 fail_count  output  $clog2(MAX_FAILS+1)  current consecutive-failure count.

Function
REQ-017 keypad_raw and submit SHALL each pass through a two-flop synchronizer; all logic uses the synchronized values (2-cycle input latency).
REQ-018 FSM states SHALL be IDLE, DEBOUNCE, PRESENT, RELEASE, LOCKOUT.
REQ-019 IDLE: on a synchronized submit of 1, go to DEBOUNCE with debounce counter = 1.
REQ-020 DEBOUNCE: the counter increments on each high sample; a low sample returns to IDLE and clears the counter; on reaching DEBOUNCE_CYCLES, capture synchronized keypad_raw and go to PRESENT.
REQ-021 On entering PRESENT, keypad_out SHALL equal the captured code for exactly HOLD_CYCLES cycles; code_valid pulses on the first of those cycles.
REQ-022 Match = (captured == MAIN_CODE) or (captured == temp_access_code), where temp_access_code is sampled in the capture cycle.
REQ-023 On match: code_accepted pulses and fail_count clears to 0.
REQ-024 On mismatch: fail_count increments, saturating at MAX_FAILS.
REQ-025 After HOLD_CYCLES, go to LOCKOUT if fail_count == MAX_FAILS; otherwise go to RELEASE.
REQ-026 RELEASE: wait for DEBOUNCE_CYCLES consecutive low submit samples, then go to IDLE; any high sample restarts that count. A held button SHALL never produce a second submission.
REQ-027 LOCKOUT: lockout = 1 and keypad_out = IDLE_CODE; submit is ignored.
REQ-028 After LOCKOUT_CYCLES cycles, LOCKOUT SHALL clear fail_count to 0 and go to RELEASE.
REQ-029 In every state other than PRESENT, keypad_out SHALL be IDLE_CODE.
REQ-030 Integration constraint: IDLE_CODE differs from MAIN_CODE, and software never programs temp_access_code to IDLE_CODE.
REQ-031 keypad_raw changes after capture SHALL NOT affect keypad_out during PRESENT.
REQ-032 All counters SHALL be sized for their parameter and SHALL NOT wrap.

Reset
REQ-033 While rst_n = 0, the state SHALL be IDLE and all counters 0.
REQ-034 While rst_n = 0: keypad_out = IDLE_CODE; code_valid = 0; code_accepted = 0; lockout = 0; fail_count = 0; synchronizer flops = 0.
REQ-035 Reset asserted mid-PRESENT or mid-LOCKOUT SHALL abort immediately, with no residual presentation or lockout.
REQ-036 Reset is released synchronously by the integrator; the block adds no internal reset synchronizer.

Structure
REQ-037 State encoding, MAIN_CODE and IDLE_CODE SHALL live in the shared home-automation package.
REQ-038 The debounce counter with its high/low compare SHALL be one sub-module, debounce_counter, reused in DEBOUNCE and RELEASE.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, MAX_FAILS=3, LOCKOUT_CYCLES=32)
REQ-039 keypad_raw=1010, submit high for 10 cycles -> one code_valid plus code_accepted; keypad_out=1010 for 8 cycles, then 0000; fail_count=0.
REQ-040 submit pulsed high for 3 cycles, then low -> no code_valid; keypad_out stays 0000.
REQ-041 Three submissions of 0011 with temp_access_code=0101 -> fail_count 1, 2, 3; lockout high for 32 cycles; a submit during lockout is ignored; afterwards fail_count=0.
REQ-042 temp_access_code=0110, two bad codes, then 0110 -> code_accepted pulses and fail_count returns to 0.
REQ-043 submit held high for 40 cycles -> exactly one code_valid.
REQ-044 rst_n driven low in PRESENT cycle 3 -> keypad_out=0000 and state IDLE with no clock edge; normal entry works after release.

Source files
------------

// File: rtl/keypad_entry_guard_pkg.sv
// Shared home-automation definitions for the keypad entry guard:
// FSM state encoding, default access codes and the code-match helper.
package keypad_entry_guard_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_PRESENT  = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

    localparam logic [3:0] MAIN_CODE_DEFAULT = 4'b1010;
    localparam logic [3:0] IDLE_CODE_DEFAULT = 4'b0000;

    // A code is good if it equals either the master code or the temporary code.
    function automatic logic code_match(input logic [3:0] code,
                                        input logic [3:0] main_code,
                                        input logic [3:0] temp_code);
        return (code == main_code) || (code == temp_code);
    endfunction

endpackage

// File: rtl/keypad_entry_guard_debounce_counter.sv
// Counts consecutive samples at a wanted level; any other sample restarts the
// count. Used for press debouncing (want_high=1) and release detection (want_high=0).
module debounce_counter #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic sample,
    input  logic want_high,
    output logic reached
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          hit;
    logic [CW-1:0] count;

    assign hit     = enable && (sample == want_high);
    assign reached = hit && (count == LAST);

    // Count matching samples; clear when disabled, on a wrong-level sample, or on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!hit || reached) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_entry_guard.sv
// Keypad entry guard: debounces the enter button, presents the captured code
// to the downstream lock for a fixed window, tracks consecutive failures and
// enforces a lockout period after too many bad codes.
module keypad_entry_guard
    import keypad_entry_guard_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         HOLD_CYCLES     = 8,
    parameter int         MAX_FAILS       = 3,
    parameter int         LOCKOUT_CYCLES  = 1024,
    parameter logic [3:0] MAIN_CODE       = MAIN_CODE_DEFAULT,
    parameter logic [3:0] IDLE_CODE       = IDLE_CODE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     keypad_raw,
    input  logic                           submit,
    input  logic [3:0]                     temp_access_code,
    output logic [3:0]                     keypad_out,
    output logic                           code_valid,
    output logic                           code_accepted,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

    logic [3:0]    key_meta, key_sync;
    logic          sub_meta, sub_sync;
    logic [2:0]    state, state_next;
    logic [3:0]    captured;
    logic          match_q;
    logic [HW-1:0] hold_cnt;
    logic [LW-1:0] lock_cnt;
    logic          deb_en, deb_want_high, deb_reached;
    logic          capture, hold_done, lock_done;

    // Two-flop synchronizers for the asynchronous switch and button inputs.
    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // so the meta->sync chain really is two stages rather than collapsing to one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '0;
            key_sync <= '0;
            sub_meta <= 1'b0;
            sub_sync <= 1'b0;
        end else begin
            key_meta <= keypad_raw;
            key_sync <= key_meta;
            sub_meta <= submit;
            sub_sync <= sub_meta;
        end
    end

    assign deb_en        = (state == ST_IDLE) || (state == ST_DEBOUNCE) || (state == ST_RELEASE);
    assign deb_want_high = (state != ST_RELEASE);

    debounce_counter #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (deb_en),
        .sample    (sub_sync),
        .want_high (deb_want_high),
        .reached   (deb_reached)
    );

    assign capture   = deb_reached && ((state == ST_IDLE) || (state == ST_DEBOUNCE));
    assign hold_done = (state == ST_PRESENT) && (hold_cnt == HOLD_LAST);
    assign lock_done = (state == ST_LOCKOUT) && (lock_cnt == LOCK_LAST);

    // Next-state selection for the entry FSM.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (capture)       state_next = ST_PRESENT;
                else if (sub_sync) state_next = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (capture)        state_next = ST_PRESENT;
                else if (!sub_sync) state_next = ST_IDLE;
            end
            ST_PRESENT: begin
                if (hold_done) state_next = (fail_count == FAIL_MAX) ? ST_LOCKOUT : ST_RELEASE;
            end
            ST_RELEASE: begin
                if (deb_reached) state_next = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (lock_done) state_next = ST_RELEASE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus presentation/lockout timers and the capture path.
    // NOTE: every flop here, including the captured code, is reset so that an
    // abort mid-presentation leaves nothing stale to reappear later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            captured <= IDLE_CODE;
            match_q  <= 1'b0;
            hold_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= (state == ST_PRESENT && !hold_done) ? hold_cnt + 1'b1 : '0;
            lock_cnt <= (state == ST_LOCKOUT && !lock_done) ? lock_cnt + 1'b1 : '0;
            if (capture) begin
                captured <= key_sync;
                match_q  <= code_match(key_sync, MAIN_CODE, temp_access_code);
            end
        end
    end

    // Consecutive-failure counter: judged at capture, cleared after a lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count <= '0;
        end else if (capture) begin
            if (code_match(key_sync, MAIN_CODE, temp_access_code)) fail_count <= '0;
            else if (fail_count != FAIL_MAX)                     fail_count <= fail_count + 1'b1;
        end else if (lock_done) begin
            fail_count <= '0;
        end
    end

    assign keypad_out    = (state == ST_PRESENT) ? captured : IDLE_CODE;
    assign code_valid    = (state == ST_PRESENT) && (hold_cnt == '0);
    assign code_accepted = code_valid && match_q;
    assign lockout       = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_keypad_entry_guard.sv
// Directed bench for keypad_entry_guard with short debounce/lockout parameters.
module tb_keypad_entry_guard;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int MAXF = 3;
    localparam int LOCK = 32;

    logic       clk;
    logic       rst_n;
    logic [3:0] keypad_raw;
    logic       submit;
    logic [3:0] temp_access_code;
    logic [3:0] keypad_out;
    logic       code_valid;
    logic       code_accepted;
    logic       lockout;
    logic [1:0] fail_count;

    int n_checks = 0;
    int n_errors = 0;

    keypad_entry_guard #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .MAX_FAILS       (MAXF),
        .LOCKOUT_CYCLES  (LOCK),
        .MAIN_CODE       (4'b1010),
        .IDLE_CODE       (4'b0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .keypad_raw       (keypad_raw),
        .submit           (submit),
        .temp_access_code (temp_access_code),
        .keypad_out       (keypad_out),
        .code_valid       (code_valid),
        .code_accepted    (code_accepted),
        .lockout          (lockout),
        .fail_count       (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic [3:0] temp;
        int         hi;       // cycles submit is held high
        int         valid;    // expected code_valid pulses
        int         acc;      // expected code_accepted pulses
        int         pres;     // expected cycles keypad_out != IDLE_CODE
        int         fail_p;   // fail_count seen during presentation
        int         lock;     // expected lockout-high cycles
        int         fail_end; // fail_count once settled
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one submission and watch the outputs over a window long enough to
    // cover debounce, presentation, any lockout and the release wait.
    task automatic run_vec(input vec_t v, input int idx);
        int n_valid = 0, n_acc = 0, n_pres = 0, n_bad = 0, n_lock = 0;
        int fail_p  = int'(fail_count);
        keypad_raw       = v.code;
        temp_access_code = v.temp;
        for (int i = 0; i < v.hi + 60; i++) begin
            @(negedge clk);
            if (code_valid) begin
                n_valid++;
                fail_p = int'(fail_count);
            end
            if (code_accepted) n_acc++;
            if (keypad_out != 4'b0000) begin
                n_pres++;
                if (keypad_out != v.code) n_bad++;
            end
            if (lockout) n_lock++;
            submit = (i < v.hi);
        end
        submit = 1'b0;
        check($sformatf("v%0d valid", idx), n_valid, v.valid);
        check($sformatf("v%0d accepted", idx), n_acc, v.acc);
        check($sformatf("v%0d present_cycles", idx), n_pres, v.pres);
        check($sformatf("v%0d wrong_code_cycles", idx), n_bad, 0);
        check($sformatf("v%0d fail_at_present", idx), fail_p, v.fail_p);
        check($sformatf("v%0d lockout_cycles", idx), n_lock, v.lock);
        check($sformatf("v%0d fail_end", idx), int'(fail_count), v.fail_end);
    endtask

    // Hold submit high and wait (bounded) for the first code_valid.
    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        submit = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (code_valid) seen = 1'b1;
        end
        check({name, " valid_seen"}, int'(seen), 1);
    endtask

    initial begin
        rst_n            = 1'b0;
        submit           = 1'b0;
        keypad_raw       = 4'b0000;
        temp_access_code = 4'b0101;

        //            code     temp     hi  val acc pres fp lock end
        vecs[0] = '{4'b1010, 4'b0101, 10, 1, 1, 8, 0, 0,    0};
        vecs[1] = '{4'b1010, 4'b0101,  3, 0, 0, 0, 0, 0,    0};
        vecs[2] = '{4'b0011, 4'b0101, 10, 1, 0, 8, 1, 0,    1};
        vecs[3] = '{4'b0011, 4'b0101, 10, 1, 0, 8, 2, 0,    2};
        vecs[4] = '{4'b0011, 4'b0101, 30, 1, 0, 8, 3, LOCK, 0};
        vecs[5] = '{4'b0001, 4'b0110, 10, 1, 0, 8, 1, 0,    1};
        vecs[6] = '{4'b0010, 4'b0110, 10, 1, 0, 8, 2, 0,    2};
        vecs[7] = '{4'b0110, 4'b0110, 10, 1, 1, 8, 0, 0,    0};
        vecs[8] = '{4'b1010, 4'b0110, 40, 1, 1, 8, 0, 0,    0};
        vecs[9] = '{4'b0101, 4'b0110, 10, 1, 0, 8, 1, 0,    1};

        #12;
        check("reset keypad_out", int'(keypad_out), 0);
        check("reset code_valid", int'(code_valid), 0);
        check("reset lockout", int'(lockout), 0);
        check("reset fail_count", int'(fail_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Changing the switches mid-presentation must not disturb keypad_out.
        begin
            int n_wrong = 0;
            keypad_raw       = 4'b0101;
            temp_access_code = 4'b0101;
            wait_valid("hold");
            keypad_raw = 4'b0000;
            for (int i = 1; i < HOLD; i++) begin
                @(negedge clk);
                if (keypad_out != 4'b0101) n_wrong++;
            end
            check("hold stable_cycles_wrong", n_wrong, 0);
            check("hold fail_count", int'(fail_count), 0);
            submit = 1'b0;
            repeat (20) @(negedge clk);
        end

        // Asynchronous reset in presentation cycle 3 aborts at once.
        keypad_raw = 4'b1010;
        wait_valid("rst");
        repeat (2) @(negedge clk);
        check("rst pre keypad_out", int'(keypad_out), 10);
        #1 rst_n = 1'b0;
        #1;
        check("rst keypad_out", int'(keypad_out), 0);
        check("rst code_valid", int'(code_valid), 0);
        check("rst code_accepted", int'(code_accepted), 0);
        check("rst lockout", int'(lockout), 0);
        check("rst fail_count", int'(fail_count), 0);
        submit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst held keypad_out", int'(keypad_out), 0);
        rst_n = 1'b1;
        run_vec(vecs[0], 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
